// File: rtl/stamp_restart_ctrl.sv
// stamp_restart_ctrl
//   Sequences software time-set commands into the stamp counter's
//   restart_time / ntp_timestamp interface on axi_aclk.
//
//   Supported operations (cmd_op):
//     00 no-op (accepted, completes immediately with status ok)
//     01 immediate load of cmd_time
//     10 immediate zero
//     11 load of cmd_time armed on the next rising edge of pps_in
//
//   After the restart pulse the block waits SETTLE_CYCLES, then compares
//   stamp_counter[W-1:6] with the expected value. The modular difference
//   must be <= VERIFY_TOL for the set to count as verified.
//
//   Command handshake: a command is taken on the clock edge where
//   cmd_valid && cmd_ready. cmd_ready is high only in IDLE, so cmd_valid
//   in any other state is ignored (nothing is queued). Completion is a
//   single-cycle done pulse with status valid in the same cycle; status
//   then holds until the next completion.
//
//   Optional feature (macro STAMP_RESTART_ABORT_EN): adds input cmd_abort.
//   In WAIT_PPS or SETTLE it ends the command with status 11, taking
//   priority over a coincident PPS edge or timeout.
//
// Ports:
//   axi_aclk, axi_resetn    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op, cmd_time        operation and load value
//   pps_in                  PPS level, synchronous to axi_aclk
//   stamp_counter           readback from the stamp counter
//   cmd_abort               (STAMP_RESTART_ABORT_EN only) abort request
//   restart_time            [0] load pulse, [1] zero pulse (registered)
//   ntp_timestamp           value latched at accept of a load op
//   busy, done, status      progress and result (00 ok, 01 verify fail,
//                           10 PPS timeout, 11 aborted)
module stamp_restart_ctrl #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int SETTLE_CYCLES   = 16,
  parameter int VERIFY_TOL      = 1024,
  parameter int PPS_TIMEOUT     = 200000000
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [TIMESTAMP_WIDTH-1:0] cmd_time,
  input  logic                       pps_in,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
`ifdef STAMP_RESTART_ABORT_EN
  input  logic                       cmd_abort,
`endif
  output logic [1:0]                 restart_time,
  output logic [TIMESTAMP_WIDTH-1:0] ntp_timestamp,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 status
);

  localparam int EW      = TIMESTAMP_WIDTH - 6;
  localparam int CNT_MAX = (PPS_TIMEOUT > SETTLE_CYCLES) ? PPS_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PPS_LAST    = CNT_W'(PPS_TIMEOUT - 1);
  localparam logic [EW-1:0]    TOL         = EW'(VERIFY_TOL);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_VFAIL   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PPS = 3'd1,
    APPLY    = 3'd2,
    SETTLE   = 3'd3,
    VERIFY   = 3'd4,
    DONE     = 3'd5
  } state_t;

  // state_q is the observable FSM state for checkers.
  state_t           state_q, state_d;
  logic             pps_q;
  logic [CNT_W-1:0] cnt_q;
  logic [EW-1:0]    exp_q;
  logic [1:0]       status_q, status_d;
  logic [1:0]       restart_q, restart_d;
  logic [TIMESTAMP_WIDTH-1:0] ntp_q;

  logic          accept;
  logic          pps_edge;
  logic          abort;
  logic [EW-1:0] diff;
  logic          verify_ok;
  logic          unused_lsbs;

`ifdef STAMP_RESTART_ABORT_EN
  assign abort = cmd_abort;
`else
  assign abort = 1'b0;
`endif

  assign accept    = cmd_valid && (state_q == IDLE);
  assign pps_edge  = pps_in && !pps_q;
  // Modular subtraction: a readback that wrapped past all-ones still
  // yields a small positive difference.
  assign diff      = stamp_counter[TIMESTAMP_WIDTH-1:6] - exp_q;
  assign verify_ok = (diff <= TOL);
  // The counter ignores the sub-bit-6 field.
  assign unused_lsbs = ^stamp_counter[5:0];

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    restart_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00: begin
              state_d  = DONE;
              status_d = ST_OK;
            end
            2'b11:   state_d = WAIT_PPS;
            default: state_d = APPLY;
          endcase
        end
      end
      WAIT_PPS: begin
        if (abort) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (pps_edge) begin
          state_d = APPLY;
        end else if (cnt_q == PPS_LAST) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end
      end
      APPLY:  state_d = SETTLE;
      SETTLE: begin
        if (abort) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        state_d  = DONE;
        status_d = verify_ok ? ST_OK : ST_VFAIL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The pulse is registered off the next state so it lines up with APPLY.
    // Only a direct zero command reaches APPLY with the zero bit; entry
    // from WAIT_PPS is always a load.
    if (state_d == APPLY) begin
      if (state_q == IDLE && cmd_op == 2'b10) restart_d = 2'b10;
      else                                    restart_d = 2'b01;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= IDLE;
      pps_q     <= 1'b0;
      cnt_q     <= '0;
      exp_q     <= '0;
      status_q  <= ST_OK;
      restart_q <= 2'b00;
      ntp_q     <= '0;
    end else begin
      state_q   <= state_d;
      pps_q     <= pps_in;
      status_q  <= status_d;
      restart_q <= restart_d;

      // One counter serves both the PPS timeout and the settle window;
      // it restarts on every state change.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_PPS || state_q == SETTLE) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (accept) begin
        if (cmd_op[0]) begin
          ntp_q <= cmd_time;
          exp_q <= cmd_time[TIMESTAMP_WIDTH-1:6];
        end else begin
          exp_q <= '0;
        end
      end
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign status        = status_q;
  assign restart_time  = restart_q;
  assign ntp_timestamp = ntp_q;

endmodule

// File: tb/tb_stamp_restart_ctrl.sv
module tb_stamp_restart_ctrl;

  localparam int W   = 64;
  localparam int S   = 16;
  localparam int TOL = 1024;
  localparam int PTO = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_time;
  logic         pps_in;
  logic [W-1:0] stamp_counter;
  logic [1:0]   restart_time;
  logic [W-1:0] ntp_timestamp;
  logic         busy;
  logic         done;
  logic [1:0]   status;
`ifdef STAMP_RESTART_ABORT_EN
  logic         cmd_abort;
`endif

  stamp_restart_ctrl #(
    .TIMESTAMP_WIDTH(W),
    .SETTLE_CYCLES(S),
    .VERIFY_TOL(TOL),
    .PPS_TIMEOUT(PTO)
  ) dut (
    .axi_aclk(clk),
    .axi_resetn(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_time(cmd_time),
    .pps_in(pps_in),
    .stamp_counter(stamp_counter),
`ifdef STAMP_RESTART_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .restart_time(restart_time),
    .ntp_timestamp(ntp_timestamp),
    .busy(busy),
    .done(done),
    .status(status)
  );

  // ---------------- stamp counter environment ----------------
  // Mode 0: loads on the load pulse, clears on the zero pulse, advances one
  // bit-6 unit per cycle. Mode 1: readback forced to sc_force.
  logic         sc_mode;
  logic [W-1:0] sc_force;
  logic [W-1:0] sc_cnt = '0;
  always @(posedge clk) begin
    if (restart_time[0])      sc_cnt <= ntp_timestamp;
    else if (restart_time[1]) sc_cnt <= '0;
    else                      sc_cnt <= sc_cnt + 64'd64;
  end
  assign stamp_counter = sc_mode ? sc_force : sc_cnt;

  // ---------------- behavioural model ----------------
  // One command at a time: accept cycle, pulse cycle/value, done cycle and
  // the status/ntp values before and after it.
  int         m_acc   = -100;
  int         m_pulse = -1;
  int         m_done  = -100;
  logic [1:0] m_pulse_val = 2'b00;
  logic [1:0] m_st_prev = 2'b00;
  logic [1:0] m_st_new  = 2'b00;
  logic [W-1:0] m_ntp_prev = '0;
  logic [W-1:0] m_ntp_new  = '0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int         last_done  = -1;
  int         last_pulse = -1;
  logic [1:0] last_pulse_val = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_busy;
      e_busy = (cyc > m_acc) && (cyc <= m_done);
      check("busy", busy, e_busy);
      check("cmd_ready", cmd_ready, !e_busy);
      check("restart_time", restart_time, (cyc == m_pulse) ? m_pulse_val : 2'b00);
      check("done", done, cyc == m_done);
      check("status", status, (cyc >= m_done) ? m_st_new : m_st_prev);
      check("ntp_timestamp", ntp_timestamp, (cyc > m_acc) ? m_ntp_new : m_ntp_prev);
    end
    if (done) last_done = cyc;
    if (restart_time != 2'b00) begin
      last_pulse     = cyc;
      last_pulse_val = restart_time;
    end
  end

  // ---------------- driver tasks ----------------
  // pps_k: wait-cycle index (relative to accept) at which PPS rises, 0 = never.
  task automatic start_cmd(input logic [1:0] op, input logic [W-1:0] t, input int pps_k,
                           input logic [1:0] exp_st, input bit pps_acc);
    @(posedge clk); #1;
    m_st_prev  = m_st_new;
    m_ntp_prev = m_ntp_new;
    m_acc      = cyc;
    last_done  = -1;
    last_pulse = -1;
    if (op[0]) m_ntp_new = t;
    case (op)
      2'b00: begin m_pulse = -1; m_done = m_acc + 1; end
      2'b01: begin m_pulse = m_acc + 1; m_pulse_val = 2'b01; m_done = m_acc + 3 + S; end
      2'b10: begin m_pulse = m_acc + 1; m_pulse_val = 2'b10; m_done = m_acc + 3 + S; end
      default: begin
        if (pps_k > 0) begin
          m_pulse = m_acc + pps_k + 1; m_pulse_val = 2'b01; m_done = m_pulse + 2 + S;
        end else begin
          m_pulse = -1; m_done = m_acc + PTO + 1;
        end
      end
    endcase
    m_st_new  = exp_st;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_time  = t;
    if (pps_acc) pps_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_time  = {$urandom, $urandom};
  endtask

  task automatic wait_loop(input int pps_cyc, input int abort_cyc, input int poke_cyc);
    for (int i = 0; i < 300; i++) begin
      if (cyc > m_done + 1) break;
      if (cyc == pps_cyc) pps_in = 1'b1;
      cmd_valid = (cyc == poke_cyc);
      if (cyc == poke_cyc) cmd_op = 2'b10;
`ifdef STAMP_RESTART_ABORT_EN
      cmd_abort = (cyc == abort_cyc);
`else
      if (abort_cyc >= 0 && cyc == abort_cyc) $display("note: abort requested without abort build");
`endif
      @(posedge clk); #1;
    end
    checks++;
    if (cyc <= m_done + 1) begin
      errors++;
      $display("FAIL wait_bound cyc=%0d actual=still_waiting expected_done_by=%0d", cyc, m_done);
    end
    pps_in    = 1'b0;
    cmd_valid = 1'b0;
`ifdef STAMP_RESTART_ABORT_EN
    cmd_abort = 1'b0;
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_time  = '0;
    pps_in    = 1'b0;
    sc_mode   = 1'b0;
    sc_force  = '0;
`ifdef STAMP_RESTART_ABORT_EN
    cmd_abort = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_restart_time", restart_time, 2'b00);
    check("rst_ntp", ntp_timestamp, 64'h0);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'b00);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Load with counter model; a second command poked while busy is ignored.
    sc_mode = 1'b0;
    start_cmd(2'b01, 64'h0000_1234_5678_9AC0, 0, 2'b00, 1'b0);
    wait_loop(-1, -1, m_acc + 5);
    check("load_pulse_lat", last_pulse - m_acc, 1);
    check("load_pulse_val", last_pulse_val, 2'b01);
    check("load_done_lat", last_done - m_acc, 19);
    check("load_ntp", ntp_timestamp, 64'h0000_1234_5678_9AC0);
    check("load_status", status, 2'b00);

    // Zero, readback 5 units above zero.
    sc_mode = 1'b1; sc_force = 64'h140;
    start_cmd(2'b10, 64'hDEAD_BEEF_0000_0000, 0, 2'b00, 1'b0);
    wait_loop(-1, -1, -1);
    check("zero_pulse_val", last_pulse_val, 2'b10);
    check("zero_ntp_kept", ntp_timestamp, 64'h0000_1234_5678_9AC0);
    check("zero_status", status, 2'b00);

    // Zero, readback far from zero.
    sc_force = 64'hFFFF_FFFF_FFFF_0000;
    start_cmd(2'b10, 64'h0, 0, 2'b01, 1'b0);
    wait_loop(-1, -1, -1);
    check("zero_bad_status", status, 2'b01);

    // PPS load, no edge: timeout.
    sc_mode = 1'b0;
    start_cmd(2'b11, 64'h0000_0000_0001_0000, 0, 2'b10, 1'b0);
    wait_loop(-1, -1, -1);
    check("pps_to_no_pulse", last_pulse, -1);
    check("pps_to_done_lat", last_done - m_acc, 51);
    check("pps_to_status", status, 2'b10);

    // PPS load, edge in wait cycle 20.
    start_cmd(2'b11, 64'h0000_0000_0002_0000, 20, 2'b00, 1'b0);
    wait_loop(m_acc + 20, -1, -1);
    check("pps_pulse_lat", last_pulse - m_acc, 21);
    check("pps_done_lat", last_done - m_acc, 39);
    check("pps_status", status, 2'b00);

    // PPS already rising in the accept cycle: not counted, so timeout.
    start_cmd(2'b11, 64'h0000_0000_0003_0000, 0, 2'b10, 1'b1);
    wait_loop(-1, -1, -1);
    check("pps_acc_no_pulse", last_pulse, -1);
    check("pps_acc_status", status, 2'b10);

    // Expected all-ones, readback wrapped to 2: difference 3.
    sc_mode = 1'b1; sc_force = 64'h80;
    start_cmd(2'b01, 64'hFFFF_FFFF_FFFF_FFC0, 0, 2'b00, 1'b0);
    wait_loop(-1, -1, -1);
    check("wrap_status", status, 2'b00);

    // Tolerance edge: exactly VERIFY_TOL passes, one more fails.
    sc_force = 64'h11000;
    start_cmd(2'b01, 64'h1000, 0, 2'b00, 1'b0);
    wait_loop(-1, -1, -1);
    check("tol_edge_status", status, 2'b00);
    sc_force = 64'h11040;
    start_cmd(2'b01, 64'h1000, 0, 2'b01, 1'b0);
    wait_loop(-1, -1, -1);
    check("tol_over_status", status, 2'b01);

    // No-op completes next cycle and overwrites the previous fail status.
    start_cmd(2'b00, 64'h5555_0000_0000_0000, 0, 2'b00, 1'b0);
    wait_loop(-1, -1, -1);
    check("noop_done_lat", last_done - m_acc, 1);
    check("noop_no_pulse", last_pulse, -1);
    check("noop_status", status, 2'b00);

    // Reset during SETTLE.
    sc_mode = 1'b0;
    start_cmd(2'b01, 64'h0000_0000_ABCD_0040, 0, 2'b00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    m_acc = -100; m_done = -100; m_pulse = -1;
    m_st_prev = 2'b00; m_st_new = 2'b00;
    m_ntp_prev = '0; m_ntp_new = '0;
    last_done = -1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ntp", ntp_timestamp, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ready", cmd_ready, 1'b1);
    repeat (25) begin @(posedge clk); #1; end
    check("midrst_no_done", last_done, -1);

    // Normal load after reset.
    start_cmd(2'b01, 64'h0000_0000_0000_1000, 0, 2'b00, 1'b0);
    wait_loop(-1, -1, -1);
    check("post_rst_status", status, 2'b00);

`ifdef STAMP_RESTART_ABORT_EN
    // Abort coincident with a PPS edge in WAIT_PPS: no pulse.
    start_cmd(2'b11, 64'h0000_0000_0009_0000, 0, 2'b11, 1'b0);
    m_pulse = -1; m_done = m_acc + 11;
    wait_loop(m_acc + 10, m_acc + 10, -1);
    check("abort_pps_no_pulse", last_pulse, -1);
    check("abort_pps_status", status, 2'b11);

    // Abort during SETTLE.
    start_cmd(2'b01, 64'h0000_0000_000A_0000, 0, 2'b11, 1'b0);
    m_done = m_acc + 6;
    wait_loop(-1, m_acc + 5, -1);
    check("abort_settle_status", status, 2'b11);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
